// File: rtl/dac_source_sequencer.sv
// ---------------------------------------------------------------------------
// dac_source_sequencer
//
// Purpose:
//   Makes glitch-free changes of the DAC source select (ADC loopback vs CORDIC)
//   and of the NCO phase increment on CPU request. Each request ramps both DAC
//   channels down to midscale, applies the new select/increment, holds muted
//   while the CORDIC pipeline flushes, then ramps back up to full scale.
//   The gain it ramps is applied to the input-mux outputs on their way to
//   the DAC.
//
// Optional feature (macro SEQ_PHASE_ALIGN_EN):
//   When defined, the switch step waits for the live phase accumulator MSB to
//   fall (accumulator wrap) before applying the new configuration. When not
//   defined the switch step lasts exactly one cycle and phase_acc_in is unused.
//
// Ports:
//   sys_clk        system clock, all state updates on its rising edge
//   rst            synchronous active-high reset
//   cfg_valid      CPU request valid
//   cfg_ready      request accepted when cfg_valid & cfg_ready
//   cfg_sel        requested source (1 = ADC, 0 = CORDIC)
//   cfg_phase_inc  requested phase increment
//   phase_acc_in   live CORDIC phase accumulator (phase-align feature only)
//   din1, din2     mux outputs, offset binary (midscale 14'h2000)
//   dout1, dout2   gain-scaled samples to the DAC (1-cycle latency)
//   input_sw_reg   mux select
//   phase_inc      NCO increment
//   busy           sequence in progress
//   done           one-cycle pulse in the last cycle of a sequence
// ---------------------------------------------------------------------------
module dac_source_sequencer #(
    parameter int              PW            = 19,
    parameter int              GW            = 8,
    parameter int              RAMP_DIV      = 4,
    parameter int              FLUSH_CYC     = 32,
    parameter logic [PW-1:0]   PHASE_INC_RST = '0
) (
    input  logic          sys_clk,
    input  logic          rst,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic          cfg_sel,
    input  logic [PW-1:0] cfg_phase_inc,
    input  logic [PW-1:0] phase_acc_in,
    input  logic [13:0]   din1,
    input  logic [13:0]   din2,
    output logic [13:0]   dout1,
    output logic [13:0]   dout2,
    output logic          input_sw_reg,
    output logic [PW-1:0] phase_inc,
    output logic          busy,
    output logic          done
);

    localparam int DIV_W  = (RAMP_DIV  > 1) ? $clog2(RAMP_DIV)  : 1;
    localparam int FL_W   = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam int PROD_W = GW + 16;

    localparam logic [DIV_W-1:0]         DIV_LAST  = DIV_W'(RAMP_DIV - 1);
    localparam logic [FL_W-1:0]          FL_LAST   = FL_W'(FLUSH_CYC - 1);
    localparam logic [GW:0]              GAIN_ONE  = {1'b1, {GW{1'b0}}};
    localparam logic [GW:0]              GAIN_STEP = (GW+1)'(1);
    localparam logic signed [PROD_W-1:0] MID_EXT   = PROD_W'(8192);

    typedef enum logic [2:0] {
        ST_RUN,
        ST_RAMP_DN,
        ST_SWITCH,
        ST_FLUSH,
        ST_RAMP_UP
    } state_t;

    state_t            state_q, state_d;
    logic [GW:0]       gain_q, gain_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [FL_W-1:0]   flush_q, flush_d;
    logic              sel_q, sel_d;
    logic [PW-1:0]     inc_q, inc_d;
    logic              sw_q, sw_d;
    logic [PW-1:0]     pinc_q, pinc_d;
    logic [13:0]       dout1_q, dout1_d;
    logic [13:0]       dout2_q, dout2_d;
    logic              tick;
    logic              align_ok;

    // Only the MSB is ever looked at (and only with the phase-align feature).
    logic unused_phase_acc;
    assign unused_phase_acc = ^phase_acc_in;

    // Offset-binary sample scaled about midscale: 8192 + ((din-8192)*gain >>> GW).
    // gain never exceeds unity, so the 14-bit result cannot overflow.
    function automatic logic [13:0] apply_gain(input logic [13:0] din, input logic [GW:0] gain);
        logic signed [PROD_W-1:0] d;
        logic signed [PROD_W-1:0] g;
        logic signed [PROD_W-1:0] p;
        logic signed [PROD_W-1:0] s;
        d = $signed({{(PROD_W-14){1'b0}}, din}) - MID_EXT;
        g = $signed({{(PROD_W-GW-1){1'b0}}, gain});
        p = d * g;
        s = p >>> GW;
        return s[13:0] + 14'h2000;
    endfunction

`ifdef SEQ_PHASE_ALIGN_EN
    logic msb_prev_q, msb_prev_d;
    always_comb msb_prev_d = phase_acc_in[PW-1];
    always_ff @(posedge sys_clk) begin
        if (rst) msb_prev_q <= 1'b0;
        else     msb_prev_q <= msb_prev_d;
    end
    // Accumulator wrap: MSB was 1 last cycle and is 0 now.
    assign align_ok = msb_prev_q & ~phase_acc_in[PW-1];
`else
    assign align_ok = 1'b1;
`endif

    assign tick = (div_q == DIV_LAST);

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can
        // leave it unassigned and infer a latch.
        state_d = state_q;
        gain_d  = gain_q;
        div_d   = '0;
        flush_d = '0;
        sel_d   = sel_q;
        inc_d   = inc_q;
        sw_d    = sw_q;
        pinc_d  = pinc_q;
        done    = 1'b0;

        case (state_q)
            ST_RUN: begin
                gain_d = GAIN_ONE;
                if (cfg_valid) begin
                    sel_d   = cfg_sel;
                    inc_d   = cfg_phase_inc;
                    state_d = ST_RAMP_DN;
                end
            end
            ST_RAMP_DN: begin
                div_d = tick ? '0 : div_q + DIV_W'(1);
                if (tick && gain_q != '0) begin
                    gain_d = gain_q - GAIN_STEP;
                    if (gain_q == GAIN_STEP) state_d = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                gain_d = '0;
                if (align_ok) begin
                    sw_d    = sel_q;
                    pinc_d  = inc_q;
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                gain_d  = '0;
                flush_d = flush_q + FL_W'(1);
                if (flush_q == FL_LAST) begin
                    flush_d = '0;
                    state_d = ST_RAMP_UP;
                end
            end
            ST_RAMP_UP: begin
                div_d = tick ? '0 : div_q + DIV_W'(1);
                if (tick && gain_q != GAIN_ONE) begin
                    gain_d = gain_q + GAIN_STEP;
                    if (gain_q == GAIN_ONE - GAIN_STEP) begin
                        state_d = ST_RUN;
                        done    = 1'b1;
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase

        // Datapath runs in every state off the current gain register.
        dout1_d = apply_gain(din1, gain_q);
        dout2_d = apply_gain(din2, gain_q);
    end

    always_ff @(posedge sys_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= ST_RUN;
            gain_q  <= GAIN_ONE;
            div_q   <= '0;
            flush_q <= '0;
            sel_q   <= 1'b0;
            inc_q   <= PHASE_INC_RST;
            sw_q    <= 1'b0;
            pinc_q  <= PHASE_INC_RST;
            dout1_q <= 14'h2000;
            dout2_q <= 14'h2000;
        end else begin
            state_q <= state_d;
            gain_q  <= gain_d;
            div_q   <= div_d;
            flush_q <= flush_d;
            sel_q   <= sel_d;
            inc_q   <= inc_d;
            sw_q    <= sw_d;
            pinc_q  <= pinc_d;
            dout1_q <= dout1_d;
            dout2_q <= dout2_d;
        end
    end

    assign cfg_ready    = (state_q == ST_RUN);
    assign busy         = (state_q != ST_RUN);
    assign input_sw_reg = sw_q;
    assign phase_inc    = pinc_q;
    assign dout1        = dout1_q;
    assign dout2        = dout2_q;

endmodule

// File: tb/tb_dac_source_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dac_source_sequencer
//
// Directed bench for dac_source_sequencer. The main instance uses GW=4,
// RAMP_DIV=1, FLUSH_CYC=8 (41-cycle sequence); a second instance with GW=2,
// RAMP_DIV=3, FLUSH_CYC=4 (29-cycle sequence) exercises the gain divider.
// Per-cycle expectations for a full sequence are queued when a request is
// driven and popped as the DUT produces each cycle's outputs.
// ---------------------------------------------------------------------------
module tb_dac_source_sequencer;

    localparam int            PW       = 19;
    localparam logic [PW-1:0] PINC_RST = 19'h00011;

    logic          sys_clk = 1'b0;
    logic          rst;
    logic          cfg_valid;
    logic          cfg_ready;
    logic          cfg_sel;
    logic [PW-1:0] cfg_phase_inc;
    logic [PW-1:0] phase_acc;
    logic [13:0]   din1, din2, dout1, dout2;
    logic          input_sw_reg;
    logic [PW-1:0] phase_inc;
    logic          busy, done;

    logic          b_valid, b_ready, b_sel, b_sw, b_busy, b_done;
    logic [PW-1:0] b_inc, b_pinc;
    logic [13:0]   b_din1, b_din2, b_dout1, b_dout2;

    always #5 sys_clk = ~sys_clk;

    dac_source_sequencer #(
        .PW(PW), .GW(4), .RAMP_DIV(1), .FLUSH_CYC(8), .PHASE_INC_RST(PINC_RST)
    ) u_dut (
        .sys_clk(sys_clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_sel(cfg_sel), .cfg_phase_inc(cfg_phase_inc),
        .phase_acc_in(phase_acc),
        .din1(din1), .din2(din2), .dout1(dout1), .dout2(dout2),
        .input_sw_reg(input_sw_reg), .phase_inc(phase_inc),
        .busy(busy), .done(done)
    );

    dac_source_sequencer #(
        .PW(PW), .GW(2), .RAMP_DIV(3), .FLUSH_CYC(4), .PHASE_INC_RST('0)
    ) u_dut_div (
        .sys_clk(sys_clk), .rst(rst),
        .cfg_valid(b_valid), .cfg_ready(b_ready),
        .cfg_sel(b_sel), .cfg_phase_inc(b_inc),
        .phase_acc_in(phase_acc),
        .din1(b_din1), .din2(b_din2), .dout1(b_dout1), .dout2(b_dout2),
        .input_sw_reg(b_sw), .phase_inc(b_pinc),
        .busy(b_busy), .done(b_done)
    );

    typedef struct {
        logic [13:0]   dout1;
        logic [13:0]   dout2;
        logic          busy;
        logic          done;
        logic          sw;
        logic [PW-1:0] pinc;
    } exp_t;

    exp_t sb_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // Expected offset-binary output for gain g out of 'one'.
    function automatic logic [13:0] exp_dout(input int din, input int g, input int one);
        return 14'(8192 + ((din - 8192) * g) / one);
    endfunction

    // Main-instance gain after the k-th edge following acceptance:
    // 16 down-steps, 1 switch cycle, 8 flush cycles, 16 up-steps.
    function automatic int gain_after(input int k);
        if (k <= 16) return 16 - k;
        if (k <= 25) return 0;
        if (k <= 41) return k - 25;
        return 16;
    endfunction

    task automatic push_seq(input int d1, input int d2, input logic sel,
                            input logic [PW-1:0] inc, input logic prev_sel,
                            input logic [PW-1:0] prev_inc);
        for (int k = 1; k <= 41; k++) begin
            exp_t e;
            e.dout1 = exp_dout(d1, gain_after(k - 1), 16);
            e.dout2 = exp_dout(d2, gain_after(k - 1), 16);
            e.busy  = (k <= 40);
            e.done  = (k == 40);
            e.sw    = (k >= 17) ? sel : prev_sel;
            e.pinc  = (k >= 17) ? inc : prev_inc;
            sb_q.push_back(e);
        end
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s: observed empty scoreboard expected entry", tag);
        end else begin
            e = sb_q.pop_front();
            chk({tag, ".dout1"}, 32'(dout1), 32'(e.dout1));
            chk({tag, ".dout2"}, 32'(dout2), 32'(e.dout2));
            chk({tag, ".busy"},  32'(busy),  32'(e.busy));
            chk({tag, ".ready"}, 32'(cfg_ready), 32'(!e.busy));
            chk({tag, ".done"},  32'(done),  32'(e.done));
            chk({tag, ".sw"},    32'(input_sw_reg), 32'(e.sw));
            chk({tag, ".pinc"},  32'(phase_inc), 32'(e.pinc));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_k, n_done, drop_k;

        rst = 1'b1; cfg_valid = 1'b0; cfg_sel = 1'b0; cfg_phase_inc = '0;
        phase_acc = '0; din1 = 14'h3000; din2 = 14'h0000;
        b_valid = 1'b0; b_sel = 1'b0; b_inc = '0; b_din1 = 14'h3000; b_din2 = 14'h2000;

        // Reset state.
        step(); step();
        chk("rst.dout1", 32'(dout1), 32'h2000);
        chk("rst.dout2", 32'(dout2), 32'h2000);
        chk("rst.ready", 32'(cfg_ready), 32'd1);
        chk("rst.busy",  32'(busy), 32'd0);
        chk("rst.done",  32'(done), 32'd0);
        chk("rst.sw",    32'(input_sw_reg), 32'd0);
        chk("rst.pinc",  32'(phase_inc), 32'(PINC_RST));
        chk("rst.b_dout1", 32'(b_dout1), 32'h2000);
        rst = 1'b0;
        step();
        chk("run.dout1", 32'(dout1), 32'h3000);
        chk("run.dout2", 32'(dout2), 32'h0000);
        chk("run.busy",  32'(busy), 32'd0);

        // First request; valid stays high through the whole sequence.
        cfg_valid = 1'b1; cfg_sel = 1'b1; cfg_phase_inc = 19'h00400;
        push_seq(32'h3000, 0, 1'b1, 19'h00400, 1'b0, PINC_RST);
        step();
        chk("acc1.busy",  32'(busy), 32'd1);
        chk("acc1.ready", 32'(cfg_ready), 32'd0);
        chk("acc1.dout1", 32'(dout1), 32'h3000);
        for (int k = 1; k <= 41; k++) begin
            step();
            pop_check($sformatf("seq1.k%0d", k));
            if (k == 10) begin
                cfg_sel = 1'b0;
                cfg_phase_inc = 19'h00777;
            end
        end

        // Held request is taken in the cycle after done.
        step();
        chk("acc2.busy", 32'(busy), 32'd1);
        chk("acc2.pinc", 32'(phase_inc), 32'h00400);
        chk("acc2.sw",   32'(input_sw_reg), 32'd1);
        cfg_valid = 1'b0;
        push_seq(32'h3000, 0, 1'b0, 19'h00777, 1'b1, 19'h00400);
        for (int k = 1; k <= 41; k++) begin
            step();
            pop_check($sformatf("seq2.k%0d", k));
        end
        step();
        chk("idle.busy", 32'(busy), 32'd0);
        chk("idle.pinc", 32'(phase_inc), 32'h00777);

        // Reset in the middle of FLUSH.
        cfg_valid = 1'b1; cfg_sel = 1'b1; cfg_phase_inc = 19'h00055;
        step();
        cfg_valid = 1'b0;
        repeat (20) step();
        chk("fl.busy",  32'(busy), 32'd1);
        chk("fl.dout1", 32'(dout1), 32'h2000);
        chk("fl.pinc",  32'(phase_inc), 32'h00055);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst.dout1", 32'(dout1), 32'h2000);
        chk("mrst.dout2", 32'(dout2), 32'h2000);
        chk("mrst.ready", 32'(cfg_ready), 32'd1);
        chk("mrst.busy",  32'(busy), 32'd0);
        chk("mrst.sw",    32'(input_sw_reg), 32'd0);
        chk("mrst.pinc",  32'(phase_inc), 32'(PINC_RST));
        step();
        chk("post.dout1", 32'(dout1), 32'h3000);
        chk("post.dout2", 32'(dout2), 32'h0000);
        chk("post.busy",  32'(busy), 32'd0);

        // Divider instance: 2*4*3 + 1 + 4 = 29-cycle sequence.
        b_valid = 1'b1; b_sel = 1'b1; b_inc = 19'h00123;
        step();
        b_valid = 1'b0;
        done_k = -1; n_done = 0; drop_k = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (k == 3) chk("div.dout_k3", 32'(b_dout1), 32'h3000);
            if (k == 4) chk("div.dout_k4", 32'(b_dout1), 32'h2C00);
            if (b_done) begin
                n_done++;
                if (done_k < 0) done_k = k;
            end
            if (!b_busy && drop_k < 0) drop_k = k;
        end
        chk("div.done_k", 32'(done_k), 32'd28);
        chk("div.n_done", 32'(n_done), 32'd1);
        chk("div.drop_k", 32'(drop_k), 32'd29);
        chk("div.pinc",   32'(b_pinc), 32'h00123);
        chk("div.dout1",  32'(b_dout1), 32'h3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
